// File: rtl/uart_prog_loader_if.sv
// Instruction-memory write port of the UART program loader.
// The loader drives this bundle (master); the instruction memory and any
// supervisor logic observe it (slave).
interface uart_prog_loader_if #(
   parameter int ADDR_W = 14
);
   logic              prog_ready_o;
   logic              we_o;
   logic [ADDR_W-1:0] addr_o;
   logic [31:0]       wdata_o;
   logic              done_o;
   logic              rx_err_o;
   logic              ovf_o;
   logic [31:0]       cksum_o;

   modport master (
      output prog_ready_o, we_o, addr_o, wdata_o,
      output done_o, rx_err_o, ovf_o, cksum_o
   );

   modport slave (
      input prog_ready_o, we_o, addr_o, wdata_o,
      input done_o, rx_err_o, ovf_o, cksum_o
   );
endinterface

// File: rtl/uart_prog_loader.sv
// UART program loader: receives 8N1 bytes, assembles them MSB first into
// 32-bit instruction words and writes them to consecutive word addresses
// until the end marker arrives or the memory is full.
// Optional feature: define PROG_LOADER_CKSUM_EN to get a running XOR
// checksum of every written word on cksum_o; otherwise cksum_o is tied to 0.
module uart_prog_loader #(
   parameter int          CLKS_PER_BIT = 87,
   parameter int          ADDR_W       = 14,
   parameter logic [31:0] END_WORD     = 32'h0000_0FFF
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               rx_i,
   uart_prog_loader_if.master bus
);

   localparam int                CNT_W     = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [1:0] {L_IDLE, L_LOAD, L_DONE}              load_state_t;

   // ---------------------------------------------------------------
   // Input synchronizer plus one delayed copy for edge detection
   // ---------------------------------------------------------------
   logic rx_meta, rx_sync, rx_sync_d;

   // Two-flop synchronizer; flops reset to the idle-high line level so
   // leaving reset never looks like a start bit.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      // NOTE: clocked state always uses non-blocking assignments so every
      // flop samples the pre-edge value of its neighbours.
      if (!rst_ni) begin
         rx_meta   <= 1'b1;
         rx_sync   <= 1'b1;
         rx_sync_d <= 1'b1;
      end else begin
         rx_meta   <= rx_i;
         rx_sync   <= rx_meta;
         rx_sync_d <= rx_sync;
      end
   end

   // ---------------------------------------------------------------
   // Receive FSM
   // ---------------------------------------------------------------
   rx_state_t        rx_state, rx_state_nxt;
   logic [CNT_W-1:0] rx_cnt, rx_cnt_nxt;
   logic [2:0]       rx_bit, rx_bit_nxt;
   logic [7:0]       rx_shift, rx_shift_nxt;
   logic             byte_valid;
   logic             frame_err;

   // Receive state, bit-timing counter and data shift register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
      end else begin
         rx_state <= rx_state_nxt;
         rx_cnt   <= rx_cnt_nxt;
         rx_bit   <= rx_bit_nxt;
         rx_shift <= rx_shift_nxt;
      end
   end

   // Receive next-state: mid-start check, eight LSB-first data samples,
   // stop sample, then straight back to idle to hunt the next start edge.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // through the case can leave one unassigned and infer a latch.
      rx_state_nxt = rx_state;
      rx_cnt_nxt   = rx_cnt + CNT_W'(1);
      rx_bit_nxt   = rx_bit;
      rx_shift_nxt = rx_shift;
      byte_valid   = 1'b0;
      frame_err    = 1'b0;
      unique case (rx_state)
         RX_IDLE: begin
            rx_cnt_nxt = '0;
            if (rx_sync_d && !rx_sync) rx_state_nxt = RX_START;
         end
         RX_START: begin
            if (rx_cnt == HALF_LAST) begin
               rx_cnt_nxt   = '0;
               rx_bit_nxt   = '0;
               rx_state_nxt = rx_sync ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (rx_cnt == BIT_LAST) begin
               rx_cnt_nxt   = '0;
               rx_shift_nxt = {rx_sync, rx_shift[7:1]};
               rx_bit_nxt   = rx_bit + 3'd1;
               if (rx_bit == 3'd7) rx_state_nxt = RX_STOP;
            end
         end
         RX_STOP: begin
            if (rx_cnt == BIT_LAST) begin
               rx_cnt_nxt   = '0;
               rx_state_nxt = RX_IDLE;
               if (rx_sync) byte_valid = 1'b1;
               else         frame_err  = 1'b1;
            end
         end
         default: rx_state_nxt = RX_IDLE;
      endcase
   end

   // ---------------------------------------------------------------
   // Load FSM and write datapath
   // ---------------------------------------------------------------
   load_state_t       l_state, l_state_nxt;
   logic [1:0]        byte_cnt;
   logic [23:0]       word_sh;
   logic [31:0]       word_asm;
   logic              take_byte;
   logic              do_write;
   logic              set_ovf;
   logic              full_q;
   logic              ready_q, we_q, done_q, err_q, ovf_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;

   // Word as it stands with the byte just received in the low lane.
   assign word_asm = {word_sh, rx_shift};

   // Load state register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) l_state <= L_IDLE;
      else         l_state <= l_state_nxt;
   end

   // Load next-state: every fourth valid byte completes a word, which is
   // either the end marker, an overflow, or a write.
   always_comb begin
      l_state_nxt = l_state;
      take_byte   = 1'b0;
      do_write    = 1'b0;
      set_ovf     = 1'b0;
      unique case (l_state)
         L_IDLE, L_LOAD: begin
            if (byte_valid) begin
               take_byte   = 1'b1;
               l_state_nxt = L_LOAD;
               if (byte_cnt == 2'd3) begin
                  if (word_asm == END_WORD) begin
                     l_state_nxt = L_DONE;
                  end else if (full_q) begin
                     set_ovf     = 1'b1;
                     l_state_nxt = L_DONE;
                  end else begin
                     do_write = 1'b1;
                  end
               end
            end
         end
         L_DONE:  l_state_nxt = L_DONE;
         default: l_state_nxt = L_IDLE;
      endcase
   end

   // Byte assembly, write strobe, address advance and status flags.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         byte_cnt <= '0;
         word_sh  <= '0;
         ready_q  <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         full_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         ready_q <= (l_state_nxt != L_DONE);
         done_q  <= (l_state_nxt == L_DONE);
         we_q    <= do_write;
         if (do_write) wdata_q <= word_asm;
         if (set_ovf)  ovf_q   <= 1'b1;
         // A framing error realigns word assembly on the next good byte.
         if (frame_err) begin
            err_q    <= 1'b1;
            byte_cnt <= '0;
         end else if (take_byte) begin
            byte_cnt <= byte_cnt + 2'd1;
            word_sh  <= word_asm[23:0];
         end
         // The last address holds and marks the memory full instead of wrapping.
         if (we_q) begin
            if (addr_q == ADDR_MAX) full_q <= 1'b1;
            else                    addr_q <= addr_q + ADDR_W'(1);
         end
      end
   end

   assign bus.prog_ready_o = ready_q;
   assign bus.we_o         = we_q;
   assign bus.addr_o       = addr_q;
   assign bus.wdata_o      = wdata_q;
   assign bus.done_o       = done_q;
   assign bus.rx_err_o     = err_q;
   assign bus.ovf_o        = ovf_q;

`ifdef PROG_LOADER_CKSUM_EN
   logic [31:0] cksum_q;

   // Running XOR of every word in the cycle it is written.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)   cksum_q <= '0;
      else if (we_q) cksum_q <= cksum_q ^ wdata_q;
   end

   assign bus.cksum_o = cksum_q;
`else
   assign bus.cksum_o = '0;
`endif

endmodule

// File: tb/tb_uart_prog_loader.sv
// Self-checking bench for uart_prog_loader. Two instances share the clock:
// dut_a with a 14-bit address space, dut_b with a 4-word space for the
// overflow case. A short bit period keeps run time small; the glitch is
// kept below half a bit so it must be rejected.
module tb_uart_prog_loader;

   localparam int          CPB   = 32;
   localparam int          AW_A  = 14;
   localparam int          AW_B  = 2;
   localparam logic [31:0] END_W = 32'h0000_0FFF;

   logic clk = 1'b0;
   logic rst_a_n, rst_b_n;
   logic rx_line;
   int   sel;
   logic rx_a, rx_b;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   assign rx_a = (sel == 0) ? rx_line : 1'b1;
   assign rx_b = (sel == 1) ? rx_line : 1'b1;

   uart_prog_loader_if #(.ADDR_W(AW_A)) bus_a ();
   uart_prog_loader_if #(.ADDR_W(AW_B)) bus_b ();

   uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW_A), .END_WORD(END_W)) dut_a (
      .clk_i (clk),
      .rst_ni(rst_a_n),
      .rx_i  (rx_a),
      .bus   (bus_a)
   );

   uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW_B), .END_WORD(END_W)) dut_b (
      .clk_i (clk),
      .rst_ni(rst_b_n),
      .rx_i  (rx_b),
      .bus   (bus_b)
   );

   // Write monitor: records {addr, data} of every strobe and counts strobes
   // that last longer than one cycle.
   logic [63:0] act_a[$];
   logic [63:0] act_b[$];
   int          dbl_a = 0, dbl_b = 0;
   logic        we_d_a = 1'b0, we_d_b = 1'b0;

   always @(negedge clk) begin
      if (bus_a.we_o === 1'b1) begin
         act_a.push_back({32'(bus_a.addr_o), bus_a.wdata_o});
         if (we_d_a) dbl_a++;
      end
      if (bus_b.we_o === 1'b1) begin
         act_b.push_back({32'(bus_b.addr_o), bus_b.wdata_o});
         if (we_d_b) dbl_b++;
      end
      we_d_a = (bus_a.we_o === 1'b1);
      we_d_b = (bus_b.we_o === 1'b1);
   end

   // Reference model: a byte stream turned into a list of expected writes.
   logic [63:0] exp_q[$];
   logic [7:0]  m_part[$];
   int          m_addr, m_depth;
   bit          m_done, m_ovf, m_err;
   logic [31:0] m_ck;

   function automatic void model_reset(input int depth);
      exp_q.delete();
      m_part.delete();
      m_addr  = 0;
      m_depth = depth;
      m_done  = 1'b0;
      m_ovf   = 1'b0;
      m_err   = 1'b0;
      m_ck    = '0;
   endfunction

   function automatic void model_byte(input logic [7:0] b, input bit ok);
      logic [31:0] w;
      if (!ok) begin
         m_err = 1'b1;
         m_part.delete();
         return;
      end
      if (m_done) return;
      m_part.push_back(b);
      if (m_part.size() == 4) begin
         w = {m_part[0], m_part[1], m_part[2], m_part[3]};
         m_part.delete();
         if (w == END_W) begin
            m_done = 1'b1;
         end else if (m_addr == m_depth) begin
            m_ovf  = 1'b1;
            m_done = 1'b1;
         end else begin
            exp_q.push_back({32'(m_addr), w});
            m_ck ^= w;
            m_addr++;
         end
      end
   endfunction

   typedef struct {
      logic        ready, we, done, err, ovf;
      logic [31:0] addr, wdata, ck;
   } obs_t;

   function automatic obs_t get_obs();
      obs_t o;
      if (sel == 0) begin
         o.ready = bus_a.prog_ready_o; o.we = bus_a.we_o; o.done = bus_a.done_o;
         o.err = bus_a.rx_err_o; o.ovf = bus_a.ovf_o; o.addr = 32'(bus_a.addr_o);
         o.wdata = bus_a.wdata_o; o.ck = bus_a.cksum_o;
      end else begin
         o.ready = bus_b.prog_ready_o; o.we = bus_b.we_o; o.done = bus_b.done_o;
         o.err = bus_b.rx_err_o; o.ovf = bus_b.ovf_o; o.addr = 32'(bus_b.addr_o);
         o.wdata = bus_b.wdata_o; o.ck = bus_b.cksum_o;
      end
      return o;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One 8N1 frame; the start bit may be stretched, the stop bit forced low.
   task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int stretch);
      rx_line = 1'b0;
      repeat (CPB + stretch) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_line = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx_line = stop_ok;
      repeat (CPB) @(negedge clk);
      rx_line = 1'b1;
      repeat (CPB) @(negedge clk);
      model_byte(b, stop_ok);
   endtask

   task automatic send_word(input logic [31:0] w, input bit rnd_stretch);
      for (int i = 3; i >= 0; i--)
         send_byte(w[8*i +: 8], 1'b1, rnd_stretch ? int'($urandom_range(0, 12)) : 0);
   endtask

   task automatic do_reset(input int which);
      obs_t o;
      sel     = which;
      rx_line = 1'b1;
      @(negedge clk);
      if (which == 0) rst_a_n = 1'b0;
      else            rst_b_n = 1'b0;
      #1;
      o = get_obs();
      check("rst_ready", 64'(o.ready), 64'd0);
      check("rst_we",    64'(o.we),    64'd0);
      check("rst_addr",  64'(o.addr),  64'd0);
      check("rst_wdata", 64'(o.wdata), 64'd0);
      check("rst_done",  64'(o.done),  64'd0);
      check("rst_err",   64'(o.err),   64'd0);
      check("rst_ovf",   64'(o.ovf),   64'd0);
      check("rst_cksum", 64'(o.ck),    64'd0);
      repeat (3) @(negedge clk);
      if (which == 0) rst_a_n = 1'b1;
      else            rst_b_n = 1'b1;
      #1;
      o = get_obs();
      check("ready_before_edge", 64'(o.ready), 64'd0);
      @(posedge clk);
      #1;
      o = get_obs();
      check("ready_first_edge", 64'(o.ready), 64'd1);
      model_reset(which == 0 ? (1 << AW_A) : (1 << AW_B));
      act_a.delete();
      act_b.delete();
      dbl_a = 0;
      dbl_b = 0;
   endtask

   task automatic compare_all(input string tag);
      obs_t        o;
      logic [63:0] act[$];
      logic [31:0] exp_ck;
      int          n;
      repeat (4) @(negedge clk);
      o = get_obs();
      if (sel == 0) act = act_a;
      else          act = act_b;
      check({tag, " nwrites"}, 64'(act.size()), 64'(exp_q.size()));
      n = (act.size() < exp_q.size()) ? act.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         check($sformatf("%s write%0d", tag, i), act[i], exp_q[i]);
      check({tag, " we_width"}, 64'(sel == 0 ? dbl_a : dbl_b), 64'd0);
      check({tag, " done"},  64'(o.done),  64'(m_done));
      check({tag, " ovf"},   64'(o.ovf),   64'(m_ovf));
      check({tag, " err"},   64'(o.err),   64'(m_err));
      check({tag, " ready"}, 64'(o.ready), 64'(!m_done));
`ifdef PROG_LOADER_CKSUM_EN
      exp_ck = m_ck;
`else
      exp_ck = 32'h0;
`endif
      check({tag, " cksum"}, 64'(o.ck), 64'(exp_ck));
   endtask

   initial begin
      logic [7:0] rb;
      rst_a_n = 1'b0;
      rst_b_n = 1'b0;
      rx_line = 1'b1;
      sel     = 0;
      repeat (4) @(negedge clk);
      rst_b_n = 1'b1;

      // Single word then end marker; later bytes ignored.
      do_reset(0);
      send_word(32'hDEADBEEF, 1'b1);
      send_word(END_W, 1'b1);
      compare_all("single_word");
      send_word(32'h12345678, 1'b0);
      compare_all("after_done");

      // Words whose data equals their address.
      do_reset(0);
      for (int i = 0; i < 16; i++) send_word(32'(i), 1'b0);
      send_word(END_W, 1'b0);
      compare_all("addr_pattern");

      // Framing error before a word, then one mid-word.
      do_reset(0);
      send_byte(8'h12, 1'b0, 0);
      for (int i = 3; i >= 0; i--) send_byte(8'(32'h11223344 >> (8*i)), 1'b1, 12);
      compare_all("frame_err_first");
      send_byte(8'hAA, 1'b1, 0);
      send_byte(8'hBB, 1'b1, 0);
      send_byte(8'hCC, 1'b0, 0);
      send_word(32'h55667788, 1'b0);
      compare_all("frame_err_midword");

      // Short low glitch on an idle line must record nothing.
      do_reset(0);
      rx_line = 1'b0;
      repeat (10) @(negedge clk);
      rx_line = 1'b1;
      repeat (3*CPB) @(negedge clk);
      compare_all("glitch");
      send_word(32'hCAFEF00D, 1'b1);
      compare_all("after_glitch");

      // Four-word memory: fifth word overflows.
      do_reset(1);
      for (int i = 0; i < 5; i++) send_word(32'h1, 1'b0);
      compare_all("overflow");

      // Reset in the middle of a word restarts at address 0.
      do_reset(0);
      send_byte(8'h77, 1'b1, 0);
      send_byte(8'h88, 1'b1, 0);
      do_reset(0);
      send_word(32'hA1B2C3D4, 1'b0);
      compare_all("reset_midword");

      // Random byte stream with occasional framing errors.
      do_reset(0);
      for (int i = 0; i < 36; i++) begin
         rb = 8'($urandom);
         send_byte(rb, ($urandom_range(0, 7) != 0), int'($urandom_range(0, 12)));
      end
      send_byte(8'h5A, 1'b0, 0);
      send_word(END_W, 1'b1);
      compare_all("random");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
